index_mask_encoder: RTL and testbench



---
 rtl/index_mask_encoder_pkg.sv | 23 ++
 rtl/index_mask_encoder_if.sv | 27 ++
 rtl/index_mask_encoder_mask_accumulator.sv | 47 ++++
 rtl/index_mask_encoder.sv | 65 ++++++
 tb/tb_index_mask_encoder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/index_mask_encoder_pkg.sv
// rtl/index_mask_encoder_pkg.sv - shared widths, state enum and one-hot helper
package index_mask_encoder_pkg;

  localparam int N_W   = 3;
  localparam int CNT_W = 4;
  localparam int M     = 1 << N_W;

  localparam logic [CNT_W-1:0] BEATS_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } enc_state_e;

  // Single-bit mask with bit idx set; also the reference decoder model.
  function automatic logic [M-1:0] onehot(input logic [N_W-1:0] idx);
    logic [M-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/index_mask_encoder_if.sv
// rtl/index_mask_encoder_if.sv - index stream in, mask result out
interface index_mask_encoder_if;
  import index_mask_encoder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [N_W-1:0]   in_idx;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_mask;
  logic [CNT_W-1:0] out_beats;
  logic             out_dup;

  // Producer of indices and consumer of results.
  modport master (
    output in_valid, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_beats, out_dup
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_beats, out_dup
  );

endinterface

// File: rtl/index_mask_encoder_mask_accumulator.sv
// rtl/index_mask_encoder_mask_accumulator.sv - per-frame mask/beat/dup accumulator
module mask_accumulator
  import index_mask_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_i,
  input  logic             last_i,
  input  logic [N_W-1:0]   idx_i,
  output logic [M-1:0]     mask_d_o,
  output logic [CNT_W-1:0] beats_d_o,
  output logic             dup_d_o
);

  logic [M-1:0]     acc_mask_q;
  logic [CNT_W-1:0] acc_beats_q;
  logic             acc_dup_q;
  logic [M-1:0]     oh;

  // Frame state including the current beat; the top captures it on the last beat.
  always_comb begin
    oh        = onehot(idx_i);
    mask_d_o  = acc_mask_q | oh;
    beats_d_o = (acc_beats_q == BEATS_MAX) ? BEATS_MAX : acc_beats_q + CNT_W'(1);
    dup_d_o   = acc_dup_q | (|(acc_mask_q & oh));
  end

  // Fold in non-last beats; a last beat hands off and starts the next frame clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_mask_q  <= '0;
      acc_beats_q <= '0;
      acc_dup_q   <= 1'b0;
    end else if (beat_i) begin
      if (last_i) begin
        acc_mask_q  <= '0;
        acc_beats_q <= '0;
        acc_dup_q   <= 1'b0;
      end else begin
        acc_mask_q  <= mask_d_o;
        acc_beats_q <= beats_d_o;
        acc_dup_q   <= dup_d_o;
      end
    end
  end

endmodule

// File: rtl/index_mask_encoder.sv
// rtl/index_mask_encoder.sv - streaming binary-index to multi-hot mask encoder
module index_mask_encoder
  import index_mask_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  index_mask_encoder_if.slave  enc
);

  enc_state_e       state_q;
  logic [M-1:0]     out_mask_q;
  logic [CNT_W-1:0] out_beats_q;
  logic             out_dup_q;

  logic             in_ready;
  logic             beat;
  logic             last_beat;
  logic [M-1:0]     mask_d;
  logic [CNT_W-1:0] beats_d;
  logic             dup_d;

  // A new beat may enter whenever the result slot is empty or being drained now.
  assign in_ready  = (state_q == IDLE) || enc.out_ready;
  assign beat      = enc.in_valid && in_ready;
  assign last_beat = beat && enc.in_last;

  mask_accumulator u_acc (
    .clk       (clk),
    .rst       (rst),
    .beat_i    (beat),
    .last_i    (enc.in_last),
    .idx_i     (enc.in_idx),
    .mask_d_o  (mask_d),
    .beats_d_o (beats_d),
    .dup_d_o   (dup_d)
  );

  // Result slot: load on a last beat, otherwise hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_mask_q  <= '0;
      out_beats_q <= '0;
      out_dup_q   <= 1'b0;
    end else begin
      if (last_beat) begin
        out_mask_q  <= mask_d;
        out_beats_q <= beats_d;
        out_dup_q   <= dup_d;
      end
      case (state_q)
        IDLE:    if (last_beat) state_q <= FULL;
        FULL:    if (!last_beat && enc.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc.in_ready  = in_ready;
  assign enc.out_valid = (state_q == FULL);
  assign enc.out_mask  = out_mask_q;
  assign enc.out_beats = out_beats_q;
  assign enc.out_dup   = out_dup_q;

endmodule

// File: tb/tb_index_mask_encoder.sv
// tb/tb_index_mask_encoder.sv - scoreboard bench for index_mask_encoder
module tb_index_mask_encoder;
  import index_mask_encoder_pkg::*;

  typedef struct packed {
    logic [M-1:0]     mask;
    logic [CNT_W-1:0] beats;
    logic             dup;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  index_mask_encoder_if bus ();

  index_mask_encoder dut (
    .clk (clk),
    .rst (rst),
    .enc (bus)
  );

  always #5 clk = ~clk;

  int        n_cmp  = 0;
  int        n_fail = 0;
  result_t   exp_q[$];
  int        frame_q[$];
  result_t   last_got;
  int        rdy_pct = 100;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mask is the set of indices seen, dup means some index occurs twice.
  function automatic result_t model_frame(input int idxs[$]);
    result_t r;
    int      count[M];
    foreach (count[i]) count[i] = 0;
    foreach (idxs[i]) count[idxs[i]]++;
    r.mask = '0;
    r.dup  = 1'b0;
    for (int b = 0; b < M; b++) begin
      if (count[b] > 0) r.mask = r.mask | (M'(1) << b);
      if (count[b] > 1) r.dup = 1'b1;
    end
    r.beats = (idxs.size() > 15) ? CNT_W'(15) : CNT_W'(idxs.size());
    return r;
  endfunction

  // Model: record accepted beats, push the expected result on the last one.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      frame_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      frame_q.push_back(int'(bus.in_idx));
      if (bus.in_last) begin
        exp_q.push_back(model_frame(frame_q));
        frame_q.delete();
      end
    end
  end

  // Monitor: valid/ready must track the scoreboard; payload must match its head.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
      if (bus.out_valid && exp_q.size() != 0) begin
        check("out_mask", bus.out_mask, exp_q[0].mask);
        check("out_beats", bus.out_beats, exp_q[0].beats);
        check("out_dup", bus.out_dup, exp_q[0].dup);
        if (bus.out_ready) begin
          last_got.mask  = bus.out_mask;
          last_got.beats = bus.out_beats;
          last_got.dup   = bus.out_dup;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input int idx, input bit last);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx[N_W-1:0];
    bus.in_last  = last;
    while (!done) begin
      if (rdy_pct >= 0) bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          n_cmp++;
          n_fail++;
          $display("FAIL beat_accept: in_ready stuck low, expected a beat to be taken");
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_mask", bus.out_mask, 0);
    check("rst_out_beats", bus.out_beats, 0);
    check("rst_out_dup", bus.out_dup, 0);
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Single beat: result one cycle later, valid for exactly one cycle.
    rdy_pct = 100;
    send_beat(5, 1'b1);
    @(negedge clk);
    check("single_valid", bus.out_valid, 1);
    check("single_mask", bus.out_mask, 32'h20);
    check("single_beats", bus.out_beats, 1);
    check("single_dup", bus.out_dup, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_valid_drop", bus.out_valid, 0);
    @(posedge clk);
    #1;

    send_beat(0, 1'b0); send_beat(3, 1'b0); send_beat(7, 1'b1);
    drain();
    check("f037_mask", last_got.mask, 32'h89);
    check("f037_beats", last_got.beats, 3);
    check("f037_dup", last_got.dup, 0);

    send_beat(2, 1'b0); send_beat(2, 1'b0); send_beat(6, 1'b1);
    drain();
    check("f226_mask", last_got.mask, 32'h44);
    check("f226_beats", last_got.beats, 3);
    check("f226_dup", last_got.dup, 1);

    // Back-pressure: stalled result holds, then release with a last beat in the same cycle.
    rdy_pct       = -1;
    bus.out_ready = 1'b0;
    send_beat(3, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_idx   = 3'd1;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_mask", bus.out_mask, 32'h08);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("release_valid", bus.out_valid, 1);
    check("release_mask", bus.out_mask, 32'h02);
    @(posedge clk);
    #1;
    drain();

    // Beat counter saturation.
    rdy_pct = 100;
    for (int b = 0; b < 19; b++) send_beat(4, 1'b0);
    send_beat(4, 1'b1);
    drain();
    check("sat_mask", last_got.mask, 32'h10);
    check("sat_beats", last_got.beats, 15);
    check("sat_dup", last_got.dup, 1);

    // Reset mid-frame discards the partial frame.
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    do_reset();
    check_reset_state();
    rdy_pct = 100;
    send_beat(0, 1'b1);
    drain();
    check("abort_mask", last_got.mask, 32'h01);
    check("abort_beats", last_got.beats, 1);
    check("abort_dup", last_got.dup, 0);

    // Random frames with random back-pressure and the odd mid-frame reset.
    for (int f = 0; f < 300; f++) begin
      int len;
      rdy_pct = $urandom_range(30, 100);
      len     = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        if (b > 0 && $urandom_range(0, 99) == 0) begin
          do_reset();
          break;
        end
        send_beat($urandom_range(0, M - 1), b == len - 1);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
